// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character LCD controller: power-on init sequence, then single-byte
// command/character writes over a 4-bit or 8-bit bus with HD44780 timing.
module lcd_hd44780_ctrl #(
    parameter int CLK_HZ = 20_000_000,
    parameter int MODE   = 1,
    parameter int LINES  = 1,
    localparam int DW    = 8 - 4 * MODE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_is_data,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          init_done,
    output logic          lcd_rs,
    output logic          lcd_rw,
    output logic          lcd_e,
    output logic [DW-1:0] lcd_data,
    output logic [2:0]    dbg_state
);

    // Handshake: a byte is taken on a rising clk edge where in_valid and
    // in_ready are both high; in_ready is high only while IDLE after init.

    function automatic int unsigned dly(input longint unsigned t_ns);
        longint unsigned c;
        c = (t_ns * $unsigned(64'(CLK_HZ)) + 64'd999_999_999) / 64'd1_000_000_000;
        return (c == 64'd0) ? 32'd1 : 32'(c);
    endfunction

    localparam int unsigned N_40NS   = dly(64'd40);
    localparam int unsigned N_250NS  = dly(64'd250);
    localparam int unsigned N_42US   = dly(64'd42_000);
    localparam int unsigned N_100US  = dly(64'd100_000);
    localparam int unsigned N_1640US = dly(64'd1_640_000);
    localparam int unsigned N_4100US = dly(64'd4_100_000);
    localparam int unsigned N_15MS   = dly(64'd15_000_000);
    localparam int          CW       = $clog2(N_15MS + 1);

    localparam logic [CW-1:0] C_40NS   = CW'(N_40NS);
    localparam logic [CW-1:0] C_250NS  = CW'(N_250NS);
    localparam logic [CW-1:0] C_42US   = CW'(N_42US);
    localparam logic [CW-1:0] C_100US  = CW'(N_100US);
    localparam logic [CW-1:0] C_1640US = CW'(N_1640US);
    localparam logic [CW-1:0] C_4100US = CW'(N_4100US);
    localparam logic [CW-1:0] C_15MS   = CW'(N_15MS);

    localparam logic [3:0] NIB_STEPS = 4'(3 + MODE);
    localparam logic [3:0] LAST_STEP = 4'(7 + MODE);
    localparam logic [7:0] FSET = 8'h20 | ((MODE == 0) ? 8'h10 : 8'h00)
                                        | ((LINES != 0) ? 8'h08 : 8'h00);

    typedef enum logic [2:0] {
        PWR_WAIT, INIT_STEP, SETUP, EN_HI, EN_LO, EXEC_WAIT, IDLE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    step;
    logic [7:0]    byte_q;
    logic          single_q;
    logic          lo_q;
    logic [CW-1:0] wait_q;

    logic          cnt_done;
    logic          start_xfer;
    logic [7:0]    item_byte;
    logic          item_single;
    logic [CW-1:0] item_wait;
    logic [7:0]    start_byte;
    logic          start_rs;
    logic          start_single;
    logic [CW-1:0] start_wait;

    function automatic logic [CW-1:0] byte_wait(input logic rs, input logic [7:0] b);
        return (!rs && (b == 8'h01 || b == 8'h02)) ? C_1640US : C_42US;
    endfunction

    function automatic logic [DW-1:0] bus_val(input logic [7:0] b, input logic lo);
        logic [7:0] v;
        if (MODE == 0)
            v = b;
        else if (lo)
            v = {4'h0, b[3:0]};
        else
            v = {4'h0, b[7:4]};
        return v[DW-1:0];
    endfunction

    assign lcd_rw    = 1'b0;
    assign dbg_state = state;
    assign cnt_done  = (cnt <= CW'(1));

    // Init table: the wake-up writes are one strobe each, the rest are full bytes.
    always_comb begin
        item_byte   = 8'h00;
        item_single = 1'b0;
        item_wait   = C_42US;
        if (step < NIB_STEPS) begin
            item_single = 1'b1;
            item_byte   = (step == 4'd3) ? 8'h20 : 8'h30;
            item_wait   = (step == 4'd0) ? C_4100US : C_100US;
        end else begin
            case (step - NIB_STEPS)
                4'd0:    item_byte = FSET;
                4'd1:    item_byte = 8'h08;
                4'd2:    item_byte = 8'h01;
                4'd3:    item_byte = 8'h06;
                default: item_byte = 8'h0C;
            endcase
            item_wait = byte_wait(1'b0, item_byte);
        end
    end

    always_comb begin
        start_xfer = (state == PWR_WAIT && cnt_done) || (state == INIT_STEP)
                   || (state == IDLE && in_valid && in_ready);
        if (state == IDLE) begin
            start_byte   = in_data;
            start_rs     = in_is_data;
            start_single = 1'b0;
            start_wait   = byte_wait(in_is_data, in_data);
        end else begin
            start_byte   = item_byte;
            start_rs     = 1'b0;
            start_single = item_single;
            start_wait   = item_wait;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= PWR_WAIT;
            cnt       <= C_15MS;
            step      <= 4'd0;
            byte_q    <= 8'h00;
            single_q  <= 1'b0;
            lo_q      <= 1'b0;
            wait_q    <= '0;
            in_ready  <= 1'b0;
            init_done <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_data  <= '0;
        end else if (start_xfer) begin
            state    <= SETUP;
            cnt      <= C_40NS;
            byte_q   <= start_byte;
            single_q <= start_single;
            wait_q   <= start_wait;
            lo_q     <= 1'b0;
            lcd_rs   <= start_rs;
            lcd_data <= bus_val(start_byte, 1'b0);
            in_ready <= 1'b0;
        end else begin
            case (state)
                PWR_WAIT: cnt <= cnt - CW'(1);
                SETUP: begin
                    if (cnt_done) begin
                        state <= EN_HI;
                        cnt   <= C_250NS;
                        lcd_e <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                EN_HI: begin
                    if (cnt_done) begin
                        state <= EN_LO;
                        cnt   <= C_40NS;
                        lcd_e <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                EN_LO: begin
                    if (!cnt_done) begin
                        cnt <= cnt - CW'(1);
                    end else if (MODE != 0 && !single_q && !lo_q) begin
                        // low nibble goes straight out, no execution wait between halves
                        state    <= SETUP;
                        cnt      <= C_40NS;
                        lo_q     <= 1'b1;
                        lcd_data <= bus_val(byte_q, 1'b1);
                    end else begin
                        state <= EXEC_WAIT;
                        cnt   <= wait_q;
                    end
                end
                EXEC_WAIT: begin
                    if (!cnt_done) begin
                        cnt <= cnt - CW'(1);
                    end else if (init_done || step == LAST_STEP) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                        in_ready  <= 1'b1;
                        lcd_rs    <= 1'b0;
                        lcd_data  <= '0;
                    end else begin
                        state <= INIT_STEP;
                        step  <= step + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Bench for lcd_hd44780_ctrl: 4-bit/2-line and 8-bit/1-line instances at a
// 500 kHz parameterised clock so the full init sequence stays short.
module tb_lcd_hd44780_ctrl;

    localparam int CLK_HZ = 500_000;
    // Cycle counts at 500 kHz: 250ns -> 1, 15ms -> 7500.
    localparam int N_EH   = 1;
    localparam int N_PWR  = 7500;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_is_data;
    logic [7:0] in_data;

    logic       in_ready4, init_done4, lcd_rs4, lcd_rw4, lcd_e4;
    logic [3:0] lcd_data4;
    logic [2:0] dbg4;
    logic       in_ready8, init_done8, lcd_rs8, lcd_rw8, lcd_e8;
    logic [7:0] lcd_data8;
    logic [2:0] dbg8;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0] exp4_q[$];
    logic [8:0] exp8_q[$];

    typedef struct {
        logic       is_data;
        logic [7:0] data;
        int         busy;
    } vec_t;
    vec_t vecs[6];

    lcd_hd44780_ctrl #(.CLK_HZ(CLK_HZ), .MODE(1), .LINES(1)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_is_data(in_is_data),
        .in_data(in_data), .in_ready(in_ready4), .init_done(init_done4),
        .lcd_rs(lcd_rs4), .lcd_rw(lcd_rw4), .lcd_e(lcd_e4),
        .lcd_data(lcd_data4), .dbg_state(dbg4)
    );

    lcd_hd44780_ctrl #(.CLK_HZ(CLK_HZ), .MODE(0), .LINES(0)) dut8 (
        .clk(clk), .rst(rst), .in_valid(1'b0), .in_is_data(1'b0),
        .in_data(8'h00), .in_ready(in_ready8), .init_done(init_done8),
        .lcd_rs(lcd_rs8), .lcd_rw(lcd_rw8), .lcd_e(lcd_e8),
        .lcd_data(lcd_data8), .dbg_state(dbg8)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard monitors: every rising E pops one expected {rs, data}
    logic       e4_prev = 1'b0;
    int         e4_len  = 0;
    logic [3:0] e4_data;
    logic [4:0] e4_exp;
    always @(negedge clk) begin
        if (!rst) begin
            e4_prev = 1'b0;
            e4_len  = 0;
        end else begin
            if (lcd_e4 && !e4_prev) begin
                if (exp4_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL strobe4_extra: got 0x%0h, expected no strobe", {lcd_rs4, lcd_data4});
                end else begin
                    e4_exp = exp4_q.pop_front();
                    check("strobe4", 32'({lcd_rs4, lcd_data4}), 32'(e4_exp));
                end
                check("rw4", 32'(lcd_rw4), 32'd0);
                e4_data = lcd_data4;
                e4_len  = 1;
            end else if (lcd_e4) begin
                e4_len++;
            end else if (e4_prev) begin
                check("e_width4", 32'(e4_len), 32'(N_EH));
                check("hold4", 32'(lcd_data4), 32'(e4_data));
            end
            e4_prev = lcd_e4;
        end
    end

    logic       e8_prev = 1'b0;
    int         e8_len  = 0;
    logic [8:0] e8_exp;
    always @(negedge clk) begin
        if (!rst) begin
            e8_prev = 1'b0;
            e8_len  = 0;
        end else begin
            if (lcd_e8 && !e8_prev) begin
                if (exp8_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL strobe8_extra: got 0x%0h, expected no strobe", {lcd_rs8, lcd_data8});
                end else begin
                    e8_exp = exp8_q.pop_front();
                    check("strobe8", 32'({lcd_rs8, lcd_data8}), 32'(e8_exp));
                end
                check("rw8", 32'(lcd_rw8), 32'd0);
                e8_len = 1;
            end else if (lcd_e8) begin
                e8_len++;
            end else if (e8_prev) begin
                check("e_width8", 32'(e8_len), 32'(N_EH));
            end
            e8_prev = lcd_e8;
        end
    end

    // driver tasks
    task automatic push_init();
        logic [3:0] n4[14];
        logic [7:0] b8[8];
        n4 = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h8,
               4'h0, 4'h1, 4'h0, 4'h6, 4'h0, 4'hC};
        b8 = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h08, 8'h01, 8'h06, 8'h0C};
        for (int i = 0; i < 14; i++) exp4_q.push_back({1'b0, n4[i]});
        for (int i = 0; i < 8; i++) exp8_q.push_back({1'b0, b8[i]});
    endtask

    task automatic wait_first_e(input string name);
        int cyc;
        cyc = 0;
        @(negedge clk);
        rst = 1'b1;
        while (!lcd_e4 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check(name, 32'(cyc), 32'(N_PWR + 1));
        check({name, "_8bit"}, 32'(lcd_e8), 32'd1);
    endtask

    task automatic wait_init();
        int cyc;
        cyc = 0;
        while (!(init_done4 && init_done8) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check("init_done4", 32'(init_done4), 32'd1);
        check("init_done8", 32'(init_done8), 32'd1);
        check("in_ready4_after_init", 32'(in_ready4), 32'd1);
        check("in_ready8_after_init", 32'(in_ready8), 32'd1);
        check("init_seq4_left", 32'(exp4_q.size()), 32'd0);
        check("init_seq8_left", 32'(exp8_q.size()), 32'd0);
        check("idle_data4", 32'(lcd_data4), 32'd0);
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!in_ready4 && cycles < 5000) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic send(input logic is_data, input logic [7:0] data, input int exp_busy);
        int busy;
        @(negedge clk);
        in_valid   = 1'b1;
        in_is_data = is_data;
        in_data    = data;
        exp4_q.push_back({is_data, data[7:4]});
        exp4_q.push_back({is_data, data[3:0]});
        @(negedge clk);
        // inputs change after the handshake; the transfer must not notice
        in_valid   = 1'b0;
        in_is_data = ~is_data;
        in_data    = ~data;
        wait_ready(busy);
        check("busy_cycles", 32'(busy), 32'(exp_busy));
        check("bytes_left", 32'(exp4_q.size()), 32'd0);
        check("idle_data", 32'(lcd_data4), 32'd0);
    endtask

    initial begin
        int cyc;
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_is_data = 1'b0;
        in_data    = 8'h00;

        vecs[0] = '{is_data: 1'b1, data: 8'h41, busy: 27};
        vecs[1] = '{is_data: 1'b0, data: 8'h01, busy: 826};
        vecs[2] = '{is_data: 1'b0, data: 8'h80, busy: 27};
        vecs[3] = '{is_data: 1'b0, data: 8'h02, busy: 826};
        vecs[4] = '{is_data: 1'b1, data: 8'h01, busy: 27};
        vecs[5] = '{is_data: 1'b0, data: 8'h03, busy: 27};

        repeat (3) @(negedge clk);
        check("rst_e4", 32'(lcd_e4), 32'd0);
        check("rst_rs4", 32'(lcd_rs4), 32'd0);
        check("rst_rw4", 32'(lcd_rw4), 32'd0);
        check("rst_data4", 32'(lcd_data4), 32'd0);
        check("rst_ready4", 32'(in_ready4), 32'd0);
        check("rst_done4", 32'(init_done4), 32'd0);
        check("rst_state4", 32'(dbg4), 32'd0);
        check("rst_data8", 32'(lcd_data8), 32'd0);
        check("rst_e8", 32'(lcd_e8), 32'd0);

        push_init();
        wait_first_e("first_e");

        // requests during init are dropped
        for (int i = 0; i < 4; i++) begin
            repeat (300) @(negedge clk);
            in_valid   = 1'b1;
            in_is_data = 1'b1;
            in_data    = 8'hA5;
            check("ready_during_init", 32'(in_ready4), 32'd0);
            @(negedge clk);
            in_valid = 1'b0;
        end
        wait_init();

        for (int i = 0; i < 6; i++) send(vecs[i].is_data, vecs[i].data, vecs[i].busy);

        // back-to-back: in_valid held high across two bytes
        @(negedge clk);
        in_valid   = 1'b1;
        in_is_data = 1'b1;
        in_data    = 8'h48;
        exp4_q.push_back({1'b1, 4'h4});
        exp4_q.push_back({1'b1, 4'h8});
        exp4_q.push_back({1'b1, 4'h4});
        exp4_q.push_back({1'b1, 4'h9});
        @(negedge clk);
        in_data = 8'h49;
        wait_ready(cyc);
        check("b2b_busy1", 32'(cyc), 32'd27);
        @(negedge clk);
        check("b2b_rehandshake", 32'(in_ready4), 32'd0);
        in_valid = 1'b0;
        wait_ready(cyc);
        check("b2b_busy2", 32'(cyc), 32'd27);
        check("b2b_left", 32'(exp4_q.size()), 32'd0);

        // reset while E is high
        @(negedge clk);
        in_valid   = 1'b1;
        in_is_data = 1'b1;
        in_data    = 8'h55;
        exp4_q.push_back({1'b1, 4'h5});
        exp4_q.push_back({1'b1, 4'h5});
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!lcd_e4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_e_high", 32'(lcd_e4), 32'd1);
        #1;
        check("mid_one_nibble_seen", 32'(exp4_q.size()), 32'd1);
        rst = 1'b0;
        #1;
        check("async_e_drop", 32'(lcd_e4), 32'd0);
        check("async_ready", 32'(in_ready4), 32'd0);
        check("async_done", 32'(init_done4), 32'd0);
        check("async_data", 32'(lcd_data4), 32'd0);
        check("async_state", 32'(dbg4), 32'd0);
        exp4_q.delete();
        repeat (2) @(negedge clk);
        push_init();
        wait_first_e("restart_first_e");
        wait_init();
        send(1'b1, 8'h7E, 27);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_ctrl.md
LCD_HD44780_CTRL -- requirements
Module: lcd_hd44780_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 20_000_000, meaning clk frequency in Hz; it is the basis of all delay-cycle counts.
REQ-002 Parameter MODE, default 1, meaning bus width: 0 = 8-bit, 1 = 4-bit.
REQ-003 Parameter LINES, default 1, meaning display lines: 0 = 1 line, 1 = 2 lines.
REQ-004 Parameter DW (derived, not overridable), meaning LCD data bus width, 8-4*MODE.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  request strobe; a transfer occurs when in_valid and in_ready are both high in the same cycle.
REQ-008 in_is_data  input  1  1 = character write (RS=1), 0 = command (RS=0).
REQ-009 in_data  input  8  byte to send.
REQ-010 in_ready  output  1  controller idle and able to accept a byte.
REQ-011 init_done  output  1  power-on init sequence has completed.
REQ-012 lcd_rs, lcd_rw, lcd_e  output  1 each  LCD control pins.
REQ-013 lcd_data  output  DW  LCD data pins.

Function
REQ-014 Delay N(t_ns) SHALL equal max(1, ceil(t_ns*CLK_HZ/1e9)) cycles; at 20 MHz: 40ns=1, 250ns=5, 42us=840, 100us=2000, 1640us=32800, 4100us=82000, 15ms=300000.
REQ-015 Single delay counter, width $clog2(N(15ms)+1); the counter is loaded on state entry and the state exits when the counter reaches 0.
REQ-016 Each bus write ("strobe") SHALL be:
- SETUP: drive RS, RW=0 and data for N(40ns);
- EN_HI: E=1 for N(250ns);
- EN_LO: E=0 for N(40ns), data held.
REQ-017 In 4-bit mode a byte is sent as two strobes, high nibble first on lcd_data[3:0]; the second nibble's SETUP follows the first nibble's EN_LO directly.
REQ-018 After the last strobe of a byte, EXEC_WAIT SHALL last:
- N(1640us) when RS=0 and in_data is 0x01 or 0x02 (clear/home);
- N(42us) otherwise.
REQ-019 FSM states: PWR_WAIT, INIT_STEP, SETUP, EN_HI, EN_LO, EXEC_WAIT, IDLE.
REQ-020 After reset, PWR_WAIT SHALL hold for N(15ms), then run the init sequence.
REQ-021 Init nibble phase, RS=0, one strobe each:
- 0x3, wait N(4100us);
- 0x3, wait N(100us);
- 0x3, wait N(100us);
- 4-bit mode only: 0x2, wait N(100us).
In 8-bit mode each value is sent as the byte 0x30.
REQ-022 Init byte phase, with normal per-byte timing:
- function set = 0x20 | (~MODE<<4) | (LINES<<3);
- 0x08;
- 0x01;
- 0x06;
- 0x0C.
REQ-023 After the last init byte's EXEC_WAIT, init_done=1 permanently until reset, and the FSM enters IDLE.
REQ-024 in_ready=1 only in IDLE with init_done=1. in_valid during init or busy SHALL be ignored, with no queuing.
REQ-025 On handshake, in_is_data and in_data SHALL be registered; later input changes do not affect the transfer in progress.
REQ-026 in_ready SHALL drop the cycle after the handshake and rise when EXEC_WAIT ends.
REQ-027 Back-to-back: in_valid held high SHALL cause a new handshake in the first IDLE cycle.
REQ-028 lcd_rw is 0 at all times; lcd_data is 0 in IDLE and PWR_WAIT.

Reset
REQ-029 While rst=0, outputs SHALL be: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0, in_ready=0, init_done=0; FSM=PWR_WAIT; counter=N(15ms).
REQ-030 Reset asserted mid-strobe SHALL drop lcd_e immediately (asynchronously). On release the full init sequence restarts.

Verification
REQ-031 Power-up at 20 MHz, 4-bit: E rises 300000+1 cycles after release; nibbles seen in order 3,3,3,2,2,8(0x28 hi/lo),0,8,0,1,0,6,0,C; then init_done=1 and in_ready=1.
REQ-032 Data write 0x41 with in_is_data=1: RS=1, nibbles 4 then 1, each E high exactly 5 cycles; in_ready low for 2*(1+5+1)+840 cycles.
REQ-033 Command 0x01 with RS=0: in_ready returns 32800 cycles after the second nibble's EN_LO; command 0x80 returns after 840 cycles.
REQ-034 in_valid pulsed during init, and a change to in_data mid-transfer: no extra strobes; the bus carries only the originally latched byte.
REQ-035 MODE=0, LINES=0: init bytes 0x30,0x30,0x30,0x30,0x08,0x01,0x06,0x0C, one strobe each on 8-bit lcd_data.
REQ-036 Reset pulsed while E=1: lcd_e=0 in the same cycle, without waiting for a clock edge; after release, PWR_WAIT restarts at the full 300000 cycles.
